// File: rtl/ysyx_24080006_rd_arbiter.sv
// Two-master AXI4 read arbiter: ICU (I) and LSU (L) share one slave read port.
// One whole read transaction (AR through last R beat) is granted at a time;
// AR/R are routed combinationally and burst beats are tracked for faults.
module ysyx_24080006_rd_arbiter #(
  parameter int PRIO_MODE = 0,  // 0: round-robin, 1: L wins ties
  parameter int MAX_LEN   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        i_araddr,
  input  logic [MAX_LEN-1:0] i_arlen,
  input  logic [2:0]         i_arsize,
  input  logic [1:0]         i_arburst,
  input  logic               i_arvalid,
  output logic               i_arready,
  output logic [31:0]        i_rdata,
  output logic [1:0]         i_rresp,
  output logic               i_rlast,
  output logic               i_rvalid,
  input  logic               i_rready,
  input  logic [31:0]        l_araddr,
  input  logic [MAX_LEN-1:0] l_arlen,
  input  logic [2:0]         l_arsize,
  input  logic [1:0]         l_arburst,
  input  logic               l_arvalid,
  output logic               l_arready,
  output logic [31:0]        l_rdata,
  output logic [1:0]         l_rresp,
  output logic               l_rlast,
  output logic               l_rvalid,
  input  logic               l_rready,
  output logic [31:0]        s_araddr,
  output logic [MAX_LEN-1:0] s_arlen,
  output logic [2:0]         s_arsize,
  output logic [1:0]         s_arburst,
  output logic               s_arvalid,
  input  logic               s_arready,
  input  logic [31:0]        s_rdata,
  input  logic [1:0]         s_rresp,
  input  logic               s_rlast,
  input  logic               s_rvalid,
  output logic               s_rready,
  output logic               busy,
  output logic               proto_err
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_L} state_e;

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;  // 0 = I, 1 = L
  logic               ar_done_q;
  logic [MAX_LEN-1:0] beat_cnt_q;
  logic [MAX_LEN-1:0] arlen_q;
  logic               proto_err_q;

  logic gnt_i, gnt_l, pick_l, ar_hs, r_hs, at_end, close_txn, err;

  assign gnt_i     = (state_q == GNT_I);
  assign gnt_l     = (state_q == GNT_L);
  assign ar_hs     = s_arvalid & s_arready;
  assign r_hs      = s_rvalid & s_rready;
  assign at_end    = (beat_cnt_q == arlen_q);
  // A beat that reaches the latched length closes the burst even without rlast.
  assign close_txn = r_hs & (s_rlast | (ar_done_q & at_end));
  assign err       = (state_q == IDLE && s_rvalid)
                   | (state_q != IDLE && s_rvalid && !ar_done_q)
                   | (r_hs & ar_done_q & (s_rlast != at_end));
  assign busy      = (state_q != IDLE);
  assign proto_err = proto_err_q;

  // Tie-break: fixed L priority, or the master that was not granted last.
  always_comb begin
    pick_l = l_arvalid;
    if (i_arvalid && l_arvalid)
      pick_l = (PRIO_MODE == 1) ? 1'b1 : ~last_grant_q;
  end

  // Next-state logic: grant from IDLE, release after the closing beat.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (i_arvalid || l_arvalid) begin
          state_d      = pick_l ? GNT_L : GNT_I;
          last_grant_d = pick_l;
        end
      end
      GNT_I, GNT_L: if (close_txn) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Channel routing: only the granted master is connected, everything else is 0.
  always_comb begin
    s_araddr  = '0;
    s_arlen   = '0;
    s_arsize  = '0;
    s_arburst = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    i_arready = 1'b0;
    l_arready = 1'b0;
    i_rdata = '0; i_rresp = '0; i_rlast = 1'b0; i_rvalid = 1'b0;
    l_rdata = '0; l_rresp = '0; l_rlast = 1'b0; l_rvalid = 1'b0;
    if (gnt_i) begin
      s_araddr  = i_araddr;
      s_arlen   = i_arlen;
      s_arsize  = i_arsize;
      s_arburst = i_arburst;
      s_arvalid = i_arvalid & ~ar_done_q;
      i_arready = s_arready & ~ar_done_q;
      s_rready  = i_rready;
      i_rdata = s_rdata; i_rresp = s_rresp; i_rlast = s_rlast; i_rvalid = s_rvalid;
    end else if (gnt_l) begin
      s_araddr  = l_araddr;
      s_arlen   = l_arlen;
      s_arsize  = l_arsize;
      s_arburst = l_arburst;
      s_arvalid = l_arvalid & ~ar_done_q;
      l_arready = s_arready & ~ar_done_q;
      s_rready  = l_rready;
      l_rdata = s_rdata; l_rresp = s_rresp; l_rlast = s_rlast; l_rvalid = s_rvalid;
    end
  end

  // State, single-AR-per-grant flag, beat counter and sticky fault flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      ar_done_q    <= 1'b0;
      beat_cnt_q   <= '0;
      arlen_q      <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      proto_err_q  <= proto_err_q | err;
      if (state_q != IDLE && state_d == IDLE) begin
        ar_done_q  <= 1'b0;
        beat_cnt_q <= '0;
      end else if (ar_hs) begin
        ar_done_q  <= 1'b1;
        beat_cnt_q <= '0;
        arlen_q    <= s_arlen;
      end else if (r_hs) begin
        beat_cnt_q <= beat_cnt_q + {{(MAX_LEN-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
